// File: rtl/bm_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : bm_mem_resp
// Purpose  : Bitmatrix column memory. Fixed-latency, fully pipelined read
//            responder with a 32-bit host lane-write port and sticky range error.
// Revision : 1.0
// ============================================================================
module bm_mem_resp #(
    parameter int BM_COL_W      = 256,
    parameter int BM_MEM_ADDR_W = 6,
    parameter int BM_DEPTH      = 48,
    parameter int RD_LAT        = 2,
    parameter int LANE_W        = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bm_cntl_bm_mem_rd_rq,
    input  logic [BM_MEM_ADDR_W-1:0] bm_cntl_bm_mem_rd_addr,
    output logic [BM_COL_W-1:0]      bm_mem_bm_cntl_rd_data,
    output logic                     bm_mem_bm_cntl_rd_data_val,
    input  logic                     host_wr_en,
    input  logic [BM_MEM_ADDR_W-1:0] host_wr_addr,
    input  logic [LANE_W-1:0]        host_wr_lane,
    input  logic [31:0]              host_wr_data,
    output logic                     bm_mem_busy,
    output logic                     bm_mem_addr_err,
    input  logic                     bm_mem_err_clr
);

    localparam logic [BM_MEM_ADDR_W:0] c_depth = (BM_MEM_ADDR_W + 1)'(BM_DEPTH);

    logic [BM_COL_W-1:0] r_mem [BM_DEPTH];
    logic [RD_LAT-1:0]   r_val;
    logic [BM_COL_W-1:0] r_dat [RD_LAT];
    logic                r_addr_err;

    logic                w_rd_in_range;
    logic                w_wr_in_range;
    logic                w_err_set;
    logic [BM_COL_W-1:0] w_rd_col;

    assign w_rd_in_range = {1'b0, bm_cntl_bm_mem_rd_addr} < c_depth;
    assign w_wr_in_range = {1'b0, host_wr_addr} < c_depth;

    // Out-of-range reads still return, but with an all-zero column.
    assign w_rd_col = w_rd_in_range ? r_mem[bm_cntl_bm_mem_rd_addr] : '0;

    assign w_err_set = (bm_cntl_bm_mem_rd_rq && !w_rd_in_range)
                     || (host_wr_en && !w_wr_in_range);

    // Memory contents survive reset; the read above sees pre-write data.
    always_ff @(posedge clk) begin
        if (host_wr_en && w_wr_in_range)
            r_mem[host_wr_addr][{host_wr_lane, 5'b0} +: 32] <= host_wr_data;
    end

    // Stage 0 holds the array read; the last stage is the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_val <= '0;
            for (int k = 0; k < RD_LAT; k++)
                r_dat[k] <= '0;
        end else begin
            r_val[0] <= bm_cntl_bm_mem_rd_rq;
            if (bm_cntl_bm_mem_rd_rq)
                r_dat[0] <= w_rd_col;
            for (int k = 1; k < RD_LAT; k++) begin
                r_val[k] <= r_val[k-1];
                if (r_val[k-1])
                    r_dat[k] <= r_dat[k-1];
            end
        end
    end

    // Set wins over clear.
    always_ff @(posedge clk) begin
        if (rst)
            r_addr_err <= 1'b0;
        else if (w_err_set)
            r_addr_err <= 1'b1;
        else if (bm_mem_err_clr)
            r_addr_err <= 1'b0;
    end

    assign bm_mem_bm_cntl_rd_data     = r_dat[RD_LAT-1];
    assign bm_mem_bm_cntl_rd_data_val = r_val[RD_LAT-1];
    assign bm_mem_busy                = |r_val;
    assign bm_mem_addr_err            = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_bm_mem_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_bm_mem_resp
// Purpose  : Self-checking bench for bm_mem_resp (RD_LAT=2 and RD_LAT=1 builds)
// Revision : 1.0
// ============================================================================
module tb_bm_mem_resp;

    localparam int COL_W = 256;
    localparam int AW    = 6;
    localparam int DEPTH = 48;
    localparam int LW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, rq, wr_en, err_clr;
    logic [AW-1:0]    rd_addr, wr_addr;
    logic [LW-1:0]    wr_lane;
    logic [31:0]      wr_data;
    logic [COL_W-1:0] d2, d1;
    logic             v2, v1, b2, b1, e2, e1;

    bm_mem_resp #(.BM_COL_W(COL_W), .BM_MEM_ADDR_W(AW), .BM_DEPTH(DEPTH),
                  .RD_LAT(2), .LANE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .bm_cntl_bm_mem_rd_rq(rq), .bm_cntl_bm_mem_rd_addr(rd_addr),
        .bm_mem_bm_cntl_rd_data(d2), .bm_mem_bm_cntl_rd_data_val(v2),
        .host_wr_en(wr_en), .host_wr_addr(wr_addr), .host_wr_lane(wr_lane),
        .host_wr_data(wr_data), .bm_mem_busy(b2), .bm_mem_addr_err(e2),
        .bm_mem_err_clr(err_clr)
    );

    bm_mem_resp #(.BM_COL_W(COL_W), .BM_MEM_ADDR_W(AW), .BM_DEPTH(DEPTH),
                  .RD_LAT(1), .LANE_W(LW)) dut_lat1 (
        .clk(clk), .rst(rst),
        .bm_cntl_bm_mem_rd_rq(rq), .bm_cntl_bm_mem_rd_addr(rd_addr),
        .bm_mem_bm_cntl_rd_data(d1), .bm_mem_bm_cntl_rd_data_val(v1),
        .host_wr_en(wr_en), .host_wr_addr(wr_addr), .host_wr_lane(wr_lane),
        .host_wr_data(wr_data), .bm_mem_busy(b1), .bm_mem_addr_err(e1),
        .bm_mem_err_clr(err_clr)
    );

    // Reference model: column array, plus a queue of (due edge, data) per build.
    typedef struct {
        int               due;
        logic [COL_W-1:0] data;
    } rd_t;

    logic [COL_W-1:0] mdl [DEPTH];
    rd_t              q2[$];
    rd_t              q1[$];
    logic [COL_W-1:0] last2, last1;
    logic             err_m;
    int               cyc = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic chk(input string tag, input logic [COL_W-1:0] obs,
                       input logic [COL_W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic idle();
        rq      = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_lane = '0;
        wr_data = '0;
        err_clr = 1'b0;
        rst     = 1'b0;
    endtask

    task automatic tick();
        logic [COL_W-1:0] rdat;
        logic             set, ev, eb;
        @(posedge clk);
        cyc++;
        if (rst) begin
            q2.delete();
            q1.delete();
            last2 = '0;
            last1 = '0;
            err_m = 1'b0;
        end else begin
            set = 1'b0;
            if (rq) begin
                rdat = (rd_addr < DEPTH) ? mdl[rd_addr] : '0;
                if (rd_addr >= DEPTH) set = 1'b1;
                q2.push_back('{cyc + 1, rdat});
                q1.push_back('{cyc, rdat});
            end
            if (wr_en && wr_addr >= DEPTH) set = 1'b1;
            err_m = set ? 1'b1 : (err_clr ? 1'b0 : err_m);
        end
        if (wr_en && wr_addr < DEPTH)
            mdl[wr_addr][wr_lane*32 +: 32] = wr_data;
        #1;
        eb = q2.size() > 0;
        ev = eb && q2[0].due == cyc;
        if (ev) begin last2 = q2[0].data; void'(q2.pop_front()); end
        chk("val_lat2", v2, ev);
        chk("data_lat2", d2, last2);
        chk("busy_lat2", b2, eb);
        chk("err_lat2", e2, err_m);
        eb = q1.size() > 0;
        ev = eb && q1[0].due == cyc;
        if (ev) begin last1 = q1[0].data; void'(q1.pop_front()); end
        chk("val_lat1", v1, ev);
        chk("data_lat1", d1, last1);
        chk("busy_lat1", b1, eb);
        chk("err_lat1", e1, err_m);
    endtask

    task automatic wr(input int col, input int lane, input logic [31:0] data);
        idle();
        wr_en   = 1'b1;
        wr_addr = AW'(col);
        wr_lane = LW'(lane);
        wr_data = data;
        tick();
    endtask

    task automatic rd(input int col);
        idle();
        rq      = 1'b1;
        rd_addr = AW'(col);
        tick();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();

        // Preload every column so later reads compare known data.
        for (int c = 0; c < DEPTH; c++)
            for (int l = 0; l < 8; l++)
                wr(c, l, $urandom);

        // Column 5 lane n = n; single read
        for (int l = 0; l < 8; l++)
            wr(5, l, 32'(l));
        rd(5);
        idle(); tick();
        chk("c5_val", v2, 1'b1);
        chk("c5_lane7", d2[255:224], 32'h7);
        chk("c5_lane0", d2[31:0], 32'h0);
        idle(); tick();
        chk("c5_busy_drop", b2, 1'b0);

        // Back-to-back reads 1, 2, 3
        for (int n = 1; n <= 3; n++)
            wr(n, 0, 32'(n));
        rd(1); rd(2); rd(3);
        idle(); tick(); tick(); tick();

        // Read-first collision on column 9
        wr(9, 2, 32'h1111_1111);
        idle();
        rq = 1'b1; rd_addr = 6'd9;
        wr_en = 1'b1; wr_addr = 6'd9; wr_lane = 3'd2; wr_data = 32'hDEAD_BEEF;
        tick();
        chk("coll_lat1_old", d1[95:64], 32'h1111_1111);
        rd(9);
        chk("coll_lat2_old", d2[95:64], 32'h1111_1111);
        chk("coll_lat1_new", d1[95:64], 32'hDEAD_BEEF);
        idle(); tick();
        chk("coll_lat2_new", d2[95:64], 32'hDEAD_BEEF);

        // Out-of-range read and error clear priority
        rd(50);
        chk("oor_err", e2, 1'b1);
        idle(); tick();
        chk("oor_val", v2, 1'b1);
        chk("oor_data", d2, '0);
        idle(); err_clr = 1'b1; wr_en = 1'b1; wr_addr = 6'd60; tick();
        chk("err_set_wins", e2, 1'b1);
        idle(); err_clr = 1'b1; tick();
        chk("err_cleared", e2, 1'b0);

        // Reset flushes in-flight reads; memory survives
        rd(5);
        idle(); rst = 1'b1; rq = 1'b1; rd_addr = 6'd6; tick();
        chk("rst_val", v2, 1'b0);
        chk("rst_busy", b2, 1'b0);
        chk("rst_data", d2, '0);
        idle(); tick(); tick();
        chk("rst_no_val", v2, 1'b0);
        rd(5);
        idle(); tick();
        chk("rst_mem_kept", d2[255:224], 32'h7);

        // Continuous 16-read stream
        for (int a = 0; a < 16; a++) begin
            rd(a);
            chk("stream_lat1_val", v1, 1'b1);
        end
        idle(); tick(); tick();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            idle();
            rst     = ($urandom_range(63) == 0);
            rq      = $urandom_range(1);
            rd_addr = AW'($urandom_range(63));
            wr_en   = ($urandom_range(9) < 3);
            wr_addr = AW'($urandom_range(63));
            wr_lane = LW'($urandom_range(7));
            wr_data = $urandom;
            err_clr = ($urandom_range(9) == 0);
            tick();
        end
        idle(); tick(); tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
